// File: rtl/sd_pkg.sv
// Shared types and defaults for the serial sequence detector stimulus controller.
package sd_pkg;

    localparam int SD_W         = 10;
    localparam int SD_DRAIN_CYC = 2;
    localparam int SD_CW        = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DRAIN,
        DONE
    } sd_state_e;

    // Pattern lengths above the shift register size are treated as full length.
    function automatic int clamp_len(input int len, input int max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/sd_hit_counter.sv
// Saturating detection counter: synchronous clear has priority over enable.
module sd_hit_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {CW{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sd_seq_ctrl.sv
// Shifts a parallel pattern LSB-first into the detector, then drains and
// reports how many cycles the detector output was high.
module sd_seq_ctrl
    import sd_pkg::*;
#(
    parameter int W         = SD_W,
    parameter int LW        = $clog2(W + 1),
    parameter int DRAIN_CYC = SD_DRAIN_CYC,
    parameter int CW        = SD_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  data_in,
    input  logic [LW-1:0] len,
    input  logic          abort,
    input  logic          sd_out,
    output logic          sd_i,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] hit_count,
    output sd_state_e     dbg_state
);

    // Handshake: start is a request sampled only in IDLE (never queued);
    // done is a one-cycle acknowledge, and a new start is taken once the
    // controller is back in IDLE. abort cancels SHIFT/DRAIN without done.
    localparam int DW = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;

    sd_state_e     state;
    logic [W-1:0]  shreg;
    logic [LW-1:0] rem;
    logic [DW-1:0] drain_cnt;
    logic [LW-1:0] len_c;
    logic          hit_clr;
    logic          hit_en;

    assign len_c     = LW'(clamp_len(int'(len), W));
    assign hit_clr   = (state == IDLE) && start;
    assign hit_en    = ((state == SHIFT) || (state == DRAIN)) && sd_out;
    assign dbg_state = state;

    sd_hit_counter #(
        .CW(CW)
    ) u_hit_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (hit_clr),
        .en   (hit_en),
        .count(hit_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            rem       <= '0;
            drain_cnt <= '0;
            sd_i      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_c != '0) begin
                            shreg <= data_in >> 1;
                            rem   <= len_c - 1'b1;
                            sd_i  <= data_in[0];
                            busy  <= 1'b1;
                            state <= SHIFT;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        sd_i  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (rem != '0) begin
                        sd_i  <= shreg[0];
                        shreg <= shreg >> 1;
                        rem   <= rem - 1'b1;
                    end else begin
                        sd_i      <= 1'b0;
                        drain_cnt <= DW'(DRAIN_CYC);
                        if (DRAIN_CYC == 0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    sd_i <= 1'b0;
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                        // Leaving on the edge that takes the count to zero.
                        if (drain_cnt == DW'(1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
